// File: rtl/pfb_multichannel_tap_acc_if.sv
// Stream bundle for the PFB tap accumulator: tap-product input side and requantized sample output side.
// The slave view belongs to the accumulator; the master view belongs to whatever drives and drains it.
interface pfb_multichannel_tap_acc_if #(
    parameter int PROD_W = 32,
    parameter int OUT_W  = 16,
    parameter int CHAN_W = 2
);
    logic [PROD_W-1:0] in_data;
    logic              in_valid;
    logic              in_sync;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic [CHAN_W-1:0] out_chan;
    logic              out_last;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, in_sync, out_ready,
        input  in_ready, out_data, out_chan, out_last, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_sync, out_ready,
        output in_ready, out_data, out_chan, out_last, out_sat, out_valid
    );
endinterface

// File: rtl/pfb_multichannel_tap_acc.sv
// Sums NTAPS tap products per channel, then rounds half-up and saturates to OUT_W bits; one sample per channel per frame.
// Result registered one cycle after the last-tap beat; in_ready drops whenever the single output register is stalled.
module pfb_multichannel_tap_acc #(
    parameter int NCHAN  = 4,
    parameter int NTAPS  = 8,
    parameter int PROD_W = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    localparam int ACC_W  = PROD_W + $clog2(NTAPS),
    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int TAP_W  = $clog2(NTAPS)
) (
    input logic                   ap_clk,
    input logic                   ap_rst,
    pfb_multichannel_tap_acc_if.slave s
);
    localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W+1)'(1) << (SHIFT-1);
    localparam logic signed [ACC_W:0] MAXV     = ((ACC_W+1)'(1) << (OUT_W-1)) - (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] MINV     = ~MAXV;
    localparam logic [OUT_W-1:0]      OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]      OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    logic [CHAN_W-1:0]       chan_cnt, eff_chan, chan_nxt;
    logic [TAP_W-1:0]        tap_cnt, eff_tap, tap_nxt;
    logic signed [ACC_W-1:0] acc [NCHAN];
    logic signed [ACC_W-1:0] ext, sum;
    logic signed [ACC_W:0]   rnd;
    logic                    accept, last_tap, sat_hi, sat_lo;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;

    // A sync beat restarts the frame at tap 0 / channel 0; the tap-0 load discards stale partial sums.
    assign eff_chan = s.in_sync ? '0 : chan_cnt;
    assign eff_tap  = s.in_sync ? '0 : tap_cnt;
    assign last_tap = (eff_tap == TAP_W'(NTAPS-1));

    assign ext = {{(ACC_W-PROD_W){s.in_data[PROD_W-1]}}, s.in_data};
    assign sum = (eff_tap == '0) ? ext : acc[eff_chan] + ext;

    // One extra bit of headroom so the rounding bias cannot wrap the largest sum.
    assign rnd    = ($signed({sum[ACC_W-1], sum}) + RND_BIAS) >>> SHIFT;
    assign sat_hi = (rnd > MAXV);
    assign sat_lo = (rnd < MINV);

    always_comb begin
        chan_nxt = eff_chan + 1'b1;
        tap_nxt  = eff_tap;
        if (eff_chan == CHAN_W'(NCHAN-1)) begin
            chan_nxt = '0;
            tap_nxt  = last_tap ? '0 : eff_tap + 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            chan_cnt    <= '0;
            tap_cnt     <= '0;
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_chan  <= '0;
            s.out_last  <= 1'b0;
            s.out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                chan_cnt <= chan_nxt;
                tap_cnt  <= tap_nxt;
            end
            if (accept && last_tap) begin
                s.out_valid <= 1'b1;
                s.out_data  <= sat_hi ? OUT_MAX : (sat_lo ? OUT_MIN : rnd[OUT_W-1:0]);
                s.out_sat   <= sat_hi || sat_lo;
                s.out_chan  <= eff_chan;
                s.out_last  <= (eff_chan == CHAN_W'(NCHAN-1));
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end

    // No reset on the bank: every channel is loaded, not added, on its tap-0 beat.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            acc[eff_chan] <= sum;
        end
    end
endmodule

// File: doc/pfb_multichannel_tap_acc.md
# pfb_multichannel_tap_acc

Consumes the stream of signed 32-bit tap products from the PFB multichannel multiplier. Sums NTAPS products per channel in a full-width accumulator, then rounds and saturates each sum back to a 16-bit sample. Emits one output sample per channel per frame, in channel order, with valid/ready flow control. It sits between the coefficient multiplier and the FFT input buffer.

## Interface
- NCHAN, 4, number of time-interleaved channels (≥1)
- NTAPS, 8, taps summed per channel per frame (≥2)
- PROD_W, 32, input product width, signed
- OUT_W, 16, output sample width, signed
- SHIFT, 15, right shift applied before requantization (≥1)
- ACC_W, PROD_W+$clog2(NTAPS), accumulator width; derived, not overridden
- ap_clk  in  1  sole clock, rising edge
- ap_rst  in  1  synchronous, active-high reset
- in_data  in  PROD_W  signed product
- in_valid  in  1  in_data valid
- in_sync  in  1  beat is tap 0 / channel 0 of a new frame; qualified by in_valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_data  out  OUT_W  rounded, saturated channel sum
- out_chan  out  $clog2(NCHAN) (min 1)  channel index of out_data
- out_last  out  1  out_data is channel NCHAN-1
- out_sat  out  1  out_data was clipped
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept

## Operation
- Input order per frame: tap-major, channel-minor: p[t=0][c=0..NCHAN-1], then p[1][...], through p[NTAPS-1][...].
- Counters chan_cnt (0..NCHAN-1) and tap_cnt (0..NTAPS-1) advance on every accepted beat.
  - chan_cnt wraps to 0, then tap_cnt increments.
  - When tap_cnt wraps to 0, the frame is complete.
- Accumulator bank acc[NCHAN], ACC_W bits each.
  - tap_cnt==0: acc[chan_cnt] ← sign-extended in_data (load, not add).
  - Otherwise: acc[chan_cnt] ← acc[chan_cnt] + sign-extended in_data.
- ACC_W guarantees no accumulator overflow for any input values.
- On an accepted beat with tap_cnt==NTAPS-1, the completed sum s = acc[chan_cnt] + in_data is requantized into the output register:
  - r = (s + 2^(SHIFT-1)) >>> SHIFT, arithmetic, computed at ACC_W+1 bits.
  - Round half toward +∞.
  - r > 2^(OUT_W-1)-1 → max positive, out_sat=1.
  - r < -2^(OUT_W-1) → min negative, out_sat=1.
  - Otherwise out_sat=0.
  - out_chan = chan_cnt; out_last = (chan_cnt==NCHAN-1).
- in_sync on an accepted beat forces that beat to be treated as tap 0 / channel 0. The counters continue from there. Partial sums of the interrupted frame are discarded: each is overwritten by its tap-0 load. No output is generated for the interrupted frame.
- in_sync on a beat that is already at tap 0 / channel 0 has no effect.

## Timing
- in_ready = !out_valid || out_ready, combinational.
  - Applies to every beat, not only last-tap beats.
  - Keeps the block to a single output register.
- Latency: last-tap beat accepted in cycle N → out_valid=1 in cycle N+1.
- Throughput: one beat per cycle while out_ready=1. Output is bursty: NCHAN consecutive samples per frame.
- out_valid clears after a handshake unless a new result loads in the same cycle.
- Simultaneous handshake and new last-tap beat: the new result replaces the old with no bubble.
- out_data, out_chan, out_last and out_sat are held stable while out_valid && !out_ready.
- Reset: chan_cnt=0, tap_cnt=0, out_valid=0, out_data=0, out_chan=0, out_last=0, out_sat=0.
  - acc[] is not reset; tap-0 load makes it irrelevant.
  - Reset mid-frame drops the partial frame. The next accepted beat is tap 0 / channel 0.
- No combinational path from in_data to any output.

## Test plan
- Reset: assert ap_rst 3 cycles mid-frame → all outputs 0, in_ready=1. The next 32 beats (NCHAN=4, NTAPS=8) yield exactly 4 outputs.
- Basic sum: ch0 products all 0x00008000, ch1 all 0x00004000, ch2 all 0, ch3 all 0xFFFF8000 → out_data 8, 4, 0, -8, out_chan 0..3, out_last only on ch3, out_sat=0.
- Rounding: ch0 tap0=0x00004000, others 0 → 1; ch1 tap0=0xFFFFC000 → 0; ch2 tap0=0xFFFFBFFF → -1.
- Saturation: ch0 all 0x7FFFFFFF → 32767, out_sat=1; ch1 all 0x80000000 → -32768, out_sat=1; ch2 all 0x3FFF8000 (sum 2^33-2^18) → 32767, out_sat=1.
- Backpressure: out_ready held low 10 cycles while frames stream → in_ready=0 while out_valid=1. Outputs are bit-identical to the free-running run with no drops or duplicates; random out_ready gives the same output sequence.
- Resync: in_sync pulsed at tap 3 / channel 2 of frame 1 → no outputs for frame 1. The following 32 beats produce a correct 4-sample frame.
